passcode_entry: RTL and testbench

PASSCODE_ENTRY -- requirements
Module: passcode_entry

---
 rtl/passcode_entry_if.sv | 31 +++
 rtl/passcode_entry.sv | 180 ++++++++++++++++++
 tb/tb_passcode_entry.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/passcode_entry_if.sv
// Keypad-side bundle for passcode_entry: key strobe, digit, commands, and the
// held code presented to the consumer together with its status flags.
interface passcode_entry_if #(
    parameter int DIGIT_W  = 3,
    parameter int N_DIGITS = 4
);
    localparam int CNT_W  = $clog2(N_DIGITS + 1);
    localparam int CODE_W = N_DIGITS * DIGIT_W;

    logic               dk;
    logic [DIGIT_W-1:0] data_key;
    logic               enter;
    logic               clear;
    logic               code_ack;
    logic [CODE_W-1:0]  code_out;
    logic               code_valid;
    logic [CNT_W-1:0]   digit_count;
    logic               overflow;
    logic               short_err;
    logic               timeout;

    modport master (
        output dk, data_key, enter, clear, code_ack,
        input  code_out, code_valid, digit_count, overflow, short_err, timeout
    );

    modport slave (
        input  dk, data_key, enter, clear, code_ack,
        output code_out, code_valid, digit_count, overflow, short_err, timeout
    );
endinterface

// File: rtl/passcode_entry.sv
// Passcode entry controller: collects keyed digits, submits a full code to a
// consumer with hold/acknowledge, and discards entries on clear, short enter or idle timeout.
module passcode_entry #(
    parameter int DIGIT_W     = 3,
    parameter int N_DIGITS    = 4,
    parameter int TIMEOUT_CYC = 4000000
) (
    input  logic                   clk,
    input  logic                   reset,
    passcode_entry_if.slave        bus
);
    localparam int CNT_W  = $clog2(N_DIGITS + 1);
    localparam int CODE_W = N_DIGITS * DIGIT_W;
    localparam int TO_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit TO_EN  = (TIMEOUT_CYC > 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT_CYC - 1) : {TO_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t              state_r, state_nx_s;
    logic                dk_q;
    logic [CODE_W-1:0]   code_r, code_nx_s;
    logic [CNT_W-1:0]    count_r, count_nx_s;
    logic [TO_W-1:0]     tcnt_r, tcnt_nx_s;
    logic                valid_r, valid_nx_s;
    logic                ovf_r, ovf_nx_s;
    logic                short_r, short_nx_s;
    logic                to_r, to_nx_s;
    logic                key_edge_s;
    logic                full_s;
    logic                to_hit_s;

    assign key_edge_s = bus.dk & ~dk_q;
    assign full_s     = (count_r == CNT_W'(N_DIGITS));
    // The timeout fires on the idle cycle that would take the counter to TIMEOUT_CYC.
    assign to_hit_s   = TO_EN & (tcnt_r == TO_LAST);

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            dk_q    <= 1'b0;
            code_r  <= {CODE_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            tcnt_r  <= {TO_W{1'b0}};
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
            short_r <= 1'b0;
            to_r    <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            dk_q    <= bus.dk;
            code_r  <= code_nx_s;
            count_r <= count_nx_s;
            tcnt_r  <= tcnt_nx_s;
            valid_r <= valid_nx_s;
            ovf_r   <= ovf_nx_s;
            short_r <= short_nx_s;
            to_r    <= to_nx_s;
        end
    end

    // Next-state selection; priority is clear, enter, key edge, then timeout.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.clear || bus.enter) begin
                    state_nx_s = ST_IDLE;
                end else if (key_edge_s) begin
                    state_nx_s = ST_ENTRY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ENTRY: begin
                if (bus.clear) begin
                    state_nx_s = ST_IDLE;
                end else if (bus.enter) begin
                    state_nx_s = full_s ? ST_HOLD : ST_IDLE;
                end else if (key_edge_s) begin
                    state_nx_s = ST_ENTRY;
                end else if (to_hit_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_ENTRY;
                end
            end
            ST_HOLD: begin
                if (bus.clear || bus.code_ack) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Next values of the code buffer, counters and status flags.
    always_comb begin
        code_nx_s  = code_r;
        count_nx_s = count_r;
        tcnt_nx_s  = {TO_W{1'b0}};
        ovf_nx_s   = ovf_r;
        short_nx_s = 1'b0;
        to_nx_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.clear) begin
                    code_nx_s  = {CODE_W{1'b0}};
                    count_nx_s = {CNT_W{1'b0}};
                    ovf_nx_s   = 1'b0;
                end else if (bus.enter) begin
                    code_nx_s  = code_r;
                end else if (key_edge_s) begin
                    code_nx_s  = (code_r << DIGIT_W) | CODE_W'(bus.data_key);
                    count_nx_s = CNT_W'(1);
                end else begin
                    code_nx_s  = code_r;
                end
            end
            ST_ENTRY: begin
                if (bus.clear) begin
                    code_nx_s  = {CODE_W{1'b0}};
                    count_nx_s = {CNT_W{1'b0}};
                    ovf_nx_s   = 1'b0;
                end else if (bus.enter) begin
                    if (!full_s) begin
                        code_nx_s  = {CODE_W{1'b0}};
                        count_nx_s = {CNT_W{1'b0}};
                        short_nx_s = 1'b1;
                    end else begin
                        code_nx_s  = code_r;
                    end
                end else if (key_edge_s) begin
                    if (!full_s) begin
                        code_nx_s  = (code_r << DIGIT_W) | CODE_W'(bus.data_key);
                        count_nx_s = count_r + CNT_W'(1);
                    end else begin
                        ovf_nx_s   = 1'b1;
                    end
                end else if (to_hit_s) begin
                    code_nx_s  = {CODE_W{1'b0}};
                    count_nx_s = {CNT_W{1'b0}};
                    ovf_nx_s   = 1'b0;
                    to_nx_s    = 1'b1;
                end else begin
                    tcnt_nx_s  = TO_EN ? (tcnt_r + TO_W'(1)) : {TO_W{1'b0}};
                end
            end
            ST_HOLD: begin
                if (bus.clear || bus.code_ack) begin
                    code_nx_s  = {CODE_W{1'b0}};
                    count_nx_s = {CNT_W{1'b0}};
                    ovf_nx_s   = 1'b0;
                end else begin
                    code_nx_s  = code_r;
                end
            end
            default: begin
                code_nx_s  = {CODE_W{1'b0}};
                count_nx_s = {CNT_W{1'b0}};
                ovf_nx_s   = 1'b0;
            end
        endcase
        valid_nx_s = (state_nx_s == ST_HOLD);
    end

    assign bus.code_out    = code_r;
    assign bus.code_valid  = valid_r;
    assign bus.digit_count = count_r;
    assign bus.overflow    = ovf_r;
    assign bus.short_err   = short_r;
    assign bus.timeout     = to_r;
endmodule

// File: tb/tb_passcode_entry.sv
// Self-checking bench for passcode_entry: directed scenarios plus random stimulus,
// compared every cycle against a digit-queue reference model.
module tb_passcode_entry;
    localparam int DW = 3;
    localparam int ND = 4;
    localparam int TO = 16;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    passcode_entry_if #(.DIGIT_W(DW), .N_DIGITS(ND)) bus ();

    passcode_entry #(.DIGIT_W(DW), .N_DIGITS(ND), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: digits kept as a queue, code computed arithmetically.
    int q[$];
    bit holding_m, ovf_m, short_m, to_m, prev_dk_m;
    int idle_m;

    function automatic logic [31:0] exp_code();
        int v = 0;
        foreach (q[i]) v = v * (1 << DW) + q[i];
        return 32'(v);
    endfunction

    task automatic model_wipe();
        q.delete();
        ovf_m     = 1'b0;
        holding_m = 1'b0;
        idle_m    = 0;
    endtask

    task automatic model_step();
        bit edge_m;
        edge_m    = bus.dk && !prev_dk_m;
        short_m   = 1'b0;
        to_m      = 1'b0;
        if (!reset) begin
            model_wipe();
            prev_dk_m = 1'b0;
            return;
        end
        prev_dk_m = bus.dk;
        if (bus.clear) begin
            model_wipe();
        end else if (holding_m) begin
            if (bus.code_ack) model_wipe();
        end else if (bus.enter) begin
            if (q.size() == ND) begin
                holding_m = 1'b1;
            end else if (q.size() > 0) begin
                q.delete();
                short_m = 1'b1;
            end
            idle_m = 0;
        end else if (edge_m) begin
            if (q.size() < ND) q.push_back(int'(bus.data_key));
            else ovf_m = 1'b1;
            idle_m = 0;
        end else if (q.size() > 0) begin
            idle_m++;
            if (idle_m == TO) begin
                model_wipe();
                to_m = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("code_out",    32'(bus.code_out),    exp_code());
        check("digit_count", 32'(bus.digit_count), 32'(q.size()));
        check("code_valid",  32'(bus.code_valid),  32'(holding_m));
        check("overflow",    32'(bus.overflow),    32'(ovf_m));
        check("short_err",   32'(bus.short_err),   32'(short_m));
        check("timeout",     32'(bus.timeout),     32'(to_m));
    endtask

    task automatic key(input int d);
        bus.dk = 1'b1;
        bus.data_key = DW'(d);
        repeat (3) tick();
        bus.dk = 1'b0;
        tick();
    endtask

    task automatic pulse_enter();
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        prev_dk_m = 1'b0;
        model_wipe();
        reset = 1'b0;
        bus.dk = 1'b0; bus.data_key = '0; bus.enter = 1'b0;
        bus.clear = 1'b0; bus.code_ack = 1'b0;
        repeat (2) tick();
        check("rst_code", 32'(bus.code_out), 32'h0);
        reset = 1'b1;

        // Full code submitted and acknowledged.
        key(5); key(2); key(7); key(1);
        pulse_enter();
        tick();
        check("c5271", 32'(bus.code_out), 32'o5271);
        check("c5271_valid", 32'(bus.code_valid), 32'd1);
        repeat (3) tick();
        bus.code_ack = 1'b1; tick(); bus.code_ack = 1'b0;
        tick();
        check("ack_clear", 32'(bus.code_out), 32'h0);

        // Short entry.
        key(3); key(4);
        pulse_enter();
        check("short_pulse", 32'(bus.short_err), 32'd1);
        tick();
        check("short_gone", 32'(bus.short_err), 32'd0);

        // Overflow then submit.
        key(1); key(2); key(3); key(4); key(6);
        check("ovf_code", 32'(bus.code_out), 32'o1234);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        pulse_enter();
        tick();
        check("ovf_valid", 32'(bus.code_valid), 32'd1);
        bus.clear = 1'b1; tick(); bus.clear = 1'b0;

        // Timeout after 16 idle cycles; none after 15 followed by a key.
        bus.dk = 1'b1; bus.data_key = 3'd7; tick(); bus.dk = 1'b0;
        repeat (15) tick();
        check("to_not_yet", 32'(bus.timeout), 32'd0);
        tick();
        check("to_fire", 32'(bus.timeout), 32'd1);
        check("to_code", 32'(bus.code_out), 32'h0);
        bus.dk = 1'b1; bus.data_key = 3'd7; tick(); bus.dk = 1'b0;
        repeat (15) tick();
        bus.dk = 1'b1; bus.data_key = 3'd2; tick(); bus.dk = 1'b0;
        check("to_saved", 32'(bus.code_out), 32'o0072);
        check("to_saved_flag", 32'(bus.timeout), 32'd0);
        bus.clear = 1'b1; tick(); bus.clear = 1'b0;

        // clear + enter + key edge in one cycle with 4 digits stored.
        key(1); key(1); key(2); key(2);
        bus.clear = 1'b1; bus.enter = 1'b1; bus.dk = 1'b1; bus.data_key = 3'd5;
        tick();
        bus.clear = 1'b0; bus.enter = 1'b0; bus.dk = 1'b0;
        check("prio_count", 32'(bus.digit_count), 32'd0);
        check("prio_short", 32'(bus.short_err), 32'd0);
        tick();

        // Reset during HOLD with dk held high across release.
        key(4); key(3); key(2); key(1);
        pulse_enter();
        tick();
        bus.dk = 1'b1; bus.data_key = 3'd6;
        reset = 1'b0; tick();
        check("hold_rst_valid", 32'(bus.code_valid), 32'd0);
        check("hold_rst_code", 32'(bus.code_out), 32'h0);
        reset = 1'b1;
        repeat (3) tick();
        check("hold_rst_cnt", 32'(bus.digit_count), 32'd1);
        bus.dk = 1'b0;
        bus.clear = 1'b1; tick(); bus.clear = 1'b0;

        // Random stimulus.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0) bus.dk = ~bus.dk;
            bus.data_key = DW'($urandom);
            bus.enter    = ($urandom_range(0, 24) == 0);
            bus.clear    = ($urandom_range(0, 59) == 0);
            bus.code_ack = ($urandom_range(0, 7) == 0);
            reset        = ($urandom_range(0, 299) != 0);
            if ((i % 500) > 470) begin
                bus.dk = 1'b0; bus.enter = 1'b0; bus.clear = 1'b0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
